pulse_width_meter: RTL and testbench

- Receive-side counterpart of pulse_extender: measures the high time of an incoming (extended) pulse in clock cycles.
- Recovers a single-cycle strobe at the pulse's rising edge.
- Presents the measured width through a valid/ack handshake.
- Sits downstream of pulse_extender (or any stretched-pulse source) in the same clock domain, or behind the optional synchronizer.

---
 rtl/pulse_width_meter.sv | 135 +++++++++++++
 tb/tb_pulse_width_meter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - measures pulse high time, strobes the rising edge, reports via valid/ack
// Optional input synchronizer: define PULSE_WIDTH_METER_SYNC_EN.
module pulse_width_meter #(
  parameter int WIDTH = 8
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_signal,
  input  logic             in_ack,
  output logic             out_pulse,
  output logic [WIDTH-1:0] out_value,
  output logic             out_valid,
  output logic             out_overflow,
  output logic             out_missed
);

  typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_t;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             prev_q, prev_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             oovf_q, oovf_d;
  logic             pulse_q, pulse_d;
  logic             missed_q, missed_d;
  logic             s;
  logic             rise;

`ifdef PULSE_WIDTH_METER_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Reset to 1 so a line already high at release is not taken as an edge.
  always_comb sync_d = {sync_q[0], in_signal};

  always_ff @(posedge in_clock) begin
    if (!in_reset) sync_q <= 2'b11;
    else           sync_q <= sync_d;
  end

  assign s = sync_q[1];
`else
  assign s = in_signal;
`endif

  assign rise   = s & ~prev_q;
  assign prev_d = s;

  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      state_q  <= IDLE;
      prev_q   <= 1'b1;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      oovf_q   <= 1'b0;
      pulse_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      oovf_q   <= oovf_d;
      pulse_q  <= pulse_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = MEASURE;
      MEASURE: if (!s) state_d = HOLD;
      HOLD:    if (in_ack) state_d = rise ? MEASURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    ovf_d    = ovf_q;
    value_d  = value_q;
    valid_d  = valid_q;
    oovf_d   = oovf_q;
    pulse_d  = 1'b0;
    missed_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          count_d = {{(WIDTH-1){1'b0}}, 1'b1};
          ovf_d   = 1'b0;
          pulse_d = 1'b1;
        end
      end
      MEASURE: begin
        if (s) begin
          if (count_q == CNT_MAX) ovf_d = 1'b1;
          else                    count_d = count_q + 1'b1;
        end else begin
          value_d = count_q;
          oovf_d  = ovf_q;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        // Ack frees the result first, so an edge on the same cycle is measured.
        if (in_ack) begin
          valid_d = 1'b0;
          oovf_d  = 1'b0;
          if (rise) begin
            count_d = {{(WIDTH-1){1'b0}}, 1'b1};
            ovf_d   = 1'b0;
            pulse_d = 1'b1;
          end
        end else if (rise) begin
          missed_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_pulse    = pulse_q;
  assign out_value    = value_q;
  assign out_valid    = valid_q;
  assign out_overflow = oovf_q;
  assign out_missed   = missed_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - table, directed and random checks of pulse_width_meter
module tb_pulse_width_meter;

`ifdef PULSE_WIDTH_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             in_reset = 1'b0;
  logic             in_signal = 1'b0;
  logic             in_ack = 1'b0;
  logic             out_pulse;
  logic [WIDTH-1:0] out_value;
  logic             out_valid;
  logic             out_overflow;
  logic             out_missed;

  int checks = 0;
  int errors = 0;

  pulse_width_meter #(.WIDTH(WIDTH)) dut (
    .in_clock(clk), .in_reset(in_reset), .in_signal(in_signal), .in_ack(in_ack),
    .out_pulse(out_pulse), .out_value(out_value), .out_valid(out_valid),
    .out_overflow(out_overflow), .out_missed(out_missed)
  );

  always #5 clk = ~clk;

  // Reference: run length kept as an unbounded integer, saturated only when reported.
  int  m_mode;
  int  m_run;
  bit  m_prev;
  bit  m_hist[$];
  bit  e_pulse, e_valid, e_ovf, e_missed;
  int  e_value;

  task automatic model_step(input bit rst, input bit sig, input bit ack);
    bit s, rise;
    if (!rst) begin
      m_prev = 1; m_mode = 0; m_run = 0;
      m_hist.delete();
      for (int i = 0; i < LAT; i++) m_hist.push_back(1'b1);
      e_pulse = 0; e_valid = 0; e_ovf = 0; e_missed = 0; e_value = 0;
      return;
    end
    if (LAT > 0) begin
      s = m_hist.pop_front();
      m_hist.push_back(sig);
    end else begin
      s = sig;
    end
    rise = s && !m_prev;
    m_prev = s;
    e_pulse = 0; e_missed = 0;
    if (m_mode == 0) begin
      if (rise) begin m_mode = 1; m_run = 1; e_pulse = 1; end
    end else if (m_mode == 1) begin
      if (s) m_run++;
      else begin
        m_mode = 2; e_valid = 1;
        e_value = (m_run > MAXV) ? MAXV : m_run;
        e_ovf = (m_run > MAXV);
      end
    end else begin
      if (ack) begin
        e_valid = 0; e_ovf = 0;
        if (rise) begin m_mode = 1; m_run = 1; e_pulse = 1; end
        else m_mode = 0;
      end else if (rise) e_missed = 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit sig, input bit ack);
    in_reset = rst; in_signal = sig; in_ack = ack;
    @(posedge clk);
    model_step(rst, sig, ack);
    #1;
    chk("pulse",    int'(out_pulse),    int'(e_pulse));
    chk("valid",    int'(out_valid),    int'(e_valid));
    chk("value",    int'(out_value),    e_value);
    chk("overflow", int'(out_overflow), int'(e_ovf));
    chk("missed",   int'(out_missed),   int'(e_missed));
  endtask

  typedef struct {
    bit sig; bit ack;
    bit pulse; bit valid; int value; bit missed;
  } vec_t;

  vec_t tbl[20];

  initial begin
    bit cur;
    int remain;
    bit rst;

    tbl[0]  = '{1,0, 1,0,0,0};
    tbl[1]  = '{0,0, 0,1,1,0};
    tbl[2]  = '{0,0, 0,1,1,0};
    tbl[3]  = '{0,1, 0,0,1,0};
    tbl[4]  = '{1,0, 1,0,1,0};
    tbl[5]  = '{1,0, 0,0,1,0};
    tbl[6]  = '{1,0, 0,0,1,0};
    tbl[7]  = '{0,0, 0,1,3,0};
    tbl[8]  = '{1,0, 0,1,3,1};
    tbl[9]  = '{1,0, 0,1,3,0};
    tbl[10] = '{0,1, 0,0,3,0};
    tbl[11] = '{1,0, 1,0,3,0};
    tbl[12] = '{0,0, 0,1,1,0};
    tbl[13] = '{1,1, 1,0,1,0};
    tbl[14] = '{1,1, 0,0,1,0};
    tbl[15] = '{0,0, 0,1,2,0};
    tbl[16] = '{0,1, 0,0,2,0};
    tbl[17] = '{1,1, 1,0,2,0};
    tbl[18] = '{0,0, 0,1,1,0};
    tbl[19] = '{0,1, 0,0,1,0};

    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);

    // Ack is delayed by the synchronizer depth so it meets the same internal state.
    for (int t = 0; t < 20 + LAT; t++) begin
      cyc(1, (t < 20) ? tbl[t].sig : 1'b0, (t >= LAT) ? tbl[t-LAT].ack : 1'b0);
      if (t >= LAT) begin
        chk("tbl_pulse",  int'(out_pulse),  int'(tbl[t-LAT].pulse));
        chk("tbl_valid",  int'(out_valid),  int'(tbl[t-LAT].valid));
        chk("tbl_value",  int'(out_value),  tbl[t-LAT].value);
        chk("tbl_missed", int'(out_missed), int'(tbl[t-LAT].missed));
      end
    end

    // Five-cycle pulse, then unacked result and a missed three-cycle pulse.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(1, 0, 0);
    chk("w5_value", int'(out_value), 5);
    chk("w5_valid", int'(out_valid), 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    chk("w5_kept", int'(out_value), 5);
    cyc(1, 0, 1);

    // Saturation: 300-cycle pulse.
    for (int i = 0; i < 300; i++) cyc(1, 1, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(1, 0, 0);
    chk("sat_value", int'(out_value), MAXV);
    chk("sat_ovf",   int'(out_overflow), 1);
    cyc(1, 0, 1);
    chk("sat_ovf_clr", int'(out_overflow), 0);

    // Exactly max width does not overflow.
    for (int i = 0; i < MAXV; i++) cyc(1, 1, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(1, 0, 0);
    chk("max_value", int'(out_value), MAXV);
    chk("max_ovf",   int'(out_overflow), 0);
    cyc(1, 0, 1);

    // Signal high across reset release, then a mid-measurement reset.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0);
    chk("hi_rel_valid", int'(out_valid), 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    chk("rst_mid_valid", int'(out_valid), 0);

    cur = 0; remain = 3;
    for (int i = 0; i < 3000; i++) begin
      if (remain == 0) begin
        cur = ~cur;
        remain = cur ? $urandom_range(1, 12) : $urandom_range(1, 5);
      end
      remain--;
      rst = ($urandom_range(0, 399) != 0);
      cyc(rst, cur, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
